// File: rtl/traffic_lamp_monitor.sv
// ---------------------------------------------------------------------------
// traffic_lamp_monitor
//
// Watches the lamp word from a cyclic traffic-lamp stage. It checks that the
// word is one-hot and that colours follow green -> yellow -> red -> green. It
// counts completed cycles and serves a pedestrian request on red entry.
//
// Optional feature (macro MONITOR_HOLD_EN):
//   undefined : any repeat of the current colour is an order fault (code 10).
//   defined   : repeats are allowed. The (MAX_HOLD+1)-th consecutive repeat
//               raises a hold-timeout fault (code 11).
//
// Ports
//   clock        in   single clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   light[0:2]   in   lamp word: 100 red, 010 green, 001 yellow
//   ped_req      in   level pedestrian request, held until ped_ack
//   fault_clr    in   synchronous clear of a sticky fault (FAULT state only)
//   fault        out  sticky fault flag
//   fault_code   out  00 none, 01 not one-hot, 10 illegal order, 11 hold timeout
//   cycle_count  out  completed green-yellow-red cycles, saturating
//   walk         out  pedestrian walk indication (only while in red)
//   ped_ack      out  one-cycle acknowledge on the red entry that serves a request
// ---------------------------------------------------------------------------
module traffic_lamp_monitor #(
    parameter int CNT_W    = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [0:2]       light,
    input  logic             ped_req,
    input  logic             fault_clr,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic             walk,
    output logic             ped_ack
);

    localparam logic [2:0] SYNC   = 3'd0;
    localparam logic [2:0] SEEN_G = 3'd1;
    localparam logic [2:0] SEEN_Y = 3'd2;
    localparam logic [2:0] SEEN_R = 3'd3;
    localparam logic [2:0] FAULT  = 3'd4;

    localparam logic [0:2] RED    = 3'b100;
    localparam logic [0:2] GREEN  = 3'b010;
    localparam logic [0:2] YELLOW = 3'b001;

    localparam logic [1:0] CODE_NONE   = 2'b00;
    localparam logic [1:0] CODE_ONEHOT = 2'b01;
    localparam logic [1:0] CODE_ORDER  = 2'b10;
`ifdef MONITOR_HOLD_EN
    localparam logic [1:0] CODE_HOLD   = 2'b11;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // A hold limit below 1 would make the first repeat a timeout. Reject it at
    // elaboration rather than build a zero-width counter.
    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("traffic_lamp_monitor: MAX_HOLD must be at least 1");
    end

    // Map a one-hot colour to the state that records it.
    function automatic logic [2:0] colour_state(input logic [0:2] l);
        case (l)
            RED:     colour_state = SEEN_R;
            GREEN:   colour_state = SEEN_G;
            default: colour_state = SEEN_Y;
        endcase
    endfunction

    // Colour that legally follows the one recorded in state s.
    function automatic logic [0:2] next_colour(input logic [2:0] s);
        case (s)
            SEEN_G:  next_colour = YELLOW;
            SEEN_Y:  next_colour = RED;
            default: next_colour = GREEN;
        endcase
    endfunction

    // Colour recorded in state s (used to detect a repeat).
    function automatic logic [0:2] current_colour(input logic [2:0] s);
        case (s)
            SEEN_G:  current_colour = GREEN;
            SEEN_Y:  current_colour = YELLOW;
            default: current_colour = RED;
        endcase
    endfunction

    logic [2:0]       state, state_next;
    logic             fault_next;
    logic [1:0]       code_next;
    logic [CNT_W-1:0] count_next;
    logic             pending, pending_next;
    logic             walk_next, ack_next;
    logic             one_hot, enter_red;

`ifdef MONITOR_HOLD_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    logic [HOLD_W-1:0] hold_cnt, hold_next;
`endif

    assign one_hot = (light == RED) || (light == GREEN) || (light == YELLOW);

    always_comb begin
        state_next = state;
        code_next  = fault_code;
        count_next = cycle_count;
`ifdef MONITOR_HOLD_EN
        // Any path other than an accepted repeat restarts the hold count.
        hold_next  = '0;
`endif
        case (state)
            SYNC: begin
                if (one_hot) begin
                    state_next = colour_state(light);
                end else if (light != 3'b000) begin
                    state_next = FAULT;
                    code_next  = CODE_ONEHOT;
                end
            end
            SEEN_G, SEEN_Y, SEEN_R: begin
                if (!one_hot) begin
                    state_next = FAULT;
                    code_next  = CODE_ONEHOT;
                end else if (light == next_colour(state)) begin
                    state_next = colour_state(light);
                    if (state == SEEN_R && cycle_count != CNT_MAX) begin
                        count_next = cycle_count + CNT_W'(1);
                    end
                end else if (light == current_colour(state)) begin
`ifdef MONITOR_HOLD_EN
                    if (hold_cnt == HOLD_LIMIT) begin
                        state_next = FAULT;
                        code_next  = CODE_HOLD;
                    end else begin
                        hold_next = hold_cnt + HOLD_W'(1);
                    end
`else
                    state_next = FAULT;
                    code_next  = CODE_ORDER;
`endif
                end else begin
                    state_next = FAULT;
                    code_next  = CODE_ORDER;
                end
            end
            FAULT: begin
                // The first fault's code is held; only an explicit clear leaves.
                if (fault_clr) begin
                    state_next = SYNC;
                    code_next  = CODE_NONE;
                end
            end
            default: begin
                state_next = SYNC;
                code_next  = CODE_NONE;
            end
        endcase
    end

    assign fault_next = (state_next == FAULT);

    // Pedestrian handling: a pending request is served only on a fresh red entry.
    // walk then persists for the whole red phase.
    assign enter_red    = (state_next == SEEN_R) && (state != SEEN_R);
    assign ack_next     = enter_red && pending;
    assign walk_next    = (state_next == SEEN_R) && (enter_red ? pending : walk);
    assign pending_next = ack_next ? 1'b0
                        : (ped_req && !walk && !ped_ack) ? 1'b1
                        : pending;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SYNC;
            fault       <= 1'b0;
            fault_code  <= CODE_NONE;
            cycle_count <= '0;
            walk        <= 1'b0;
            ped_ack     <= 1'b0;
            pending     <= 1'b0;
        end else begin
            state       <= state_next;
            fault       <= fault_next;
            fault_code  <= code_next;
            cycle_count <= count_next;
            walk        <= walk_next;
            ped_ack     <= ack_next;
            pending     <= pending_next;
        end
    end

`ifdef MONITOR_HOLD_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_next;
        end
    end
`endif

endmodule

// File: doc/traffic_lamp_monitor.md
TRAFFIC_LAMP_MONITOR -- requirements
Module: traffic_lamp_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of the completed-cycle counter.
REQ-002 Parameter MAX_HOLD, default 15: maximum consecutive repeats of one colour; used only with MONITOR_HOLD_EN.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 light  input  [0:2]  lamp word from the cyclic lamp stage: 3'b100 red, 3'b010 green, 3'b001 yellow.
REQ-006 ped_req  input  1  level pedestrian request, held high until ped_ack is seen.
REQ-007 fault_clr  input  1  synchronous clear of a sticky fault.
REQ-008 fault  output  1  sticky fault flag.
REQ-009 fault_code  output  2  00 none, 01 not one-hot, 10 illegal order, 11 hold timeout.
REQ-010 cycle_count  output  CNT_W  count of completed green-yellow-red cycles.
REQ-011 walk  output  1  pedestrian walk indication.
REQ-012 ped_ack  output  1  one-cycle acknowledge of ped_req.

Function
REQ-013 light SHALL be sampled on every rising edge, and all outputs SHALL be registered and reflect that sample after the same edge.
REQ-014 The FSM SHALL use the states SYNC, SEEN_G, SEEN_Y, SEEN_R and FAULT.
REQ-015 SYNC transitions: a valid one-hot colour goes to the matching SEEN_x state; 3'b000 stays in SYNC with no fault; any other non-one-hot value goes to FAULT.
REQ-016 The legal order SHALL be green->yellow->red->green: SEEN_G accepts yellow, SEEN_Y accepts red and SEEN_R accepts green.
REQ-017 From any SEEN_x state, a non-one-hot sample (including 3'b000) SHALL go to FAULT with code 01.
REQ-018 From any SEEN_x state, a one-hot colour out of order SHALL go to FAULT with code 10.
REQ-019 Repeat of the current colour SHALL be handled per the Configuration section.
REQ-020 The transition SEEN_R->SEEN_G SHALL increment cycle_count by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-021 In FAULT, fault=1 and fault_code SHALL hold the first fault's code, and later faults SHALL NOT overwrite it.
REQ-022 FAULT exits to SYNC only on fault_clr=1, clearing fault and fault_code to 00; cycle_count is retained.
REQ-023 fault_clr sampled outside FAULT SHALL have no effect.
REQ-024 If fault_clr is high on the same edge as a newly detected fault, the new fault SHALL win.
REQ-025 The pedestrian request SHALL be latched as pending when ped_req=1, walk=0 and ped_ack=0.
REQ-026 On entry to SEEN_R with the request pending, walk SHALL be 1 and ped_ack SHALL be 1 for exactly that cycle; the pending flag SHALL then clear.
REQ-027 walk SHALL stay 1 while in SEEN_R and SHALL drop on the edge that leaves SEEN_R.
REQ-028 A request arriving while in SEEN_R SHALL be served at the next red entry.
REQ-029 In SYNC and FAULT, walk=0 and ped_ack=0, and the pending request SHALL be kept.

Reset
REQ-030 reset_n=0 SHALL immediately force: state SYNC, fault=0, fault_code=00, cycle_count=0, walk=0, ped_ack=0, pending=0, hold counter 0.
REQ-031 Reset asserted mid-cycle or mid-walk SHALL abort without an ack pulse.
REQ-032 After reset release, the first valid colour SHALL be accepted as in REQ-015.

Configuration
REQ-033 Macro MONITOR_HOLD_EN, when defined, SHALL allow a repeat of the current colour.
REQ-034 With MONITOR_HOLD_EN defined, a hold counter SHALL count consecutive repeats and reset on each legal colour change.
REQ-035 With MONITOR_HOLD_EN defined, the repeat that would bring the count to MAX_HOLD+1 SHALL go to FAULT with code 11.
REQ-036 Without MONITOR_HOLD_EN, a repeat SHALL go to FAULT with code 10, no hold counter SHALL exist, and code 11 SHALL never occur.

Verification
REQ-037 Reset, then feed G,Y,R repeated 3 times then G -> cycle_count=3, fault=0.
REQ-038 In SEEN_G, apply light=3'b110 -> fault=1, code 01; then apply R -> code remains 01.
REQ-039 Apply G then R -> fault=1, code 10; then fault_clr=1 with light=G -> SYNC, code 00, count retained; next Y is accepted.
REQ-040 Raise ped_req during G, then feed Y,R,G -> walk=1 during R only, one-cycle ped_ack on R entry, no second ack.
REQ-041 With MONITOR_HOLD_EN and MAX_HOLD=3, apply G for 4 cycles -> no fault; a 5th G -> code 11. Without MONITOR_HOLD_EN, the second G -> code 10.
REQ-042 With CNT_W=2, run 5 full cycles -> cycle_count=3 saturated; assert reset_n=0 during walk -> walk=0 and ped_ack=0 immediately.
